// File: rtl/timer_pkg.sv
// Shared encodings, register bit positions and small helpers for the
// two-channel 8-bit timer unit control logic.
package timer_pkg;

  localparam int PRESC_WIDTH = 13;

  typedef enum logic [1:0] {
    PROHIBITED   = 2'b00,
    RISING_EDGE  = 2'b01,
    FALLING_EDGE = 2'b10,
    BOTH_EDGES   = 2'b11
  } edge_e;

  typedef enum logic [2:0] {
    CKS_STOP     = 3'b000,
    CKS_DIV_A    = 3'b001,
    CKS_DIV_B    = 3'b010,
    CKS_DIV_C    = 3'b011,
    CKS_CASCADE  = 3'b100,
    CKS_EXT_RISE = 3'b101,
    CKS_EXT_FALL = 3'b110,
    CKS_EXT_BOTH = 3'b111
  } cks_e;

  typedef enum logic [1:0] {
    CCLR_NONE = 2'b00,
    CCLR_CMA  = 2'b01,
    CCLR_CMB  = 2'b10,
    CCLR_TMRI = 2'b11
  } cclr_e;

  typedef enum logic [1:0] {
    OS_HOLD   = 2'b00,
    OS_LOW    = 2'b01,
    OS_HIGH   = 2'b10,
    OS_TOGGLE = 2'b11
  } os_e;

  localparam int TCR_CMIEB     = 7;
  localparam int TCR_CMIEA     = 6;
  localparam int TCR_OVIE      = 5;
  localparam int TCR_CCLR_MSB  = 4;
  localparam int TCR_CCLR_LSB  = 3;
  localparam int TCSR_CMFB     = 7;
  localparam int TCSR_CMFA     = 6;
  localparam int TCSR_OVF      = 5;
  localparam int TCSR_ADTE     = 4;
  localparam int TCCR_TMRIS    = 3;

  // Prescaler bits that must all be ones for an internal-clock count tick.
  function automatic logic [PRESC_WIDTH-1:0] prescale_mask(cks_e cks, logic icks0);
    case (cks)
      CKS_DIV_A: return icks0 ? 13'h0001 : 13'h0007;
      CKS_DIV_B: return icks0 ? 13'h001F : 13'h003F;
      CKS_DIV_C: return icks0 ? 13'h03FF : 13'h1FFF;
      default:   return 13'h0000;
    endcase
  endfunction

  function automatic logic os_apply(os_e os, logic cur);
    case (os)
      OS_LOW:    return 1'b0;
      OS_HIGH:   return 1'b1;
      OS_TOGGLE: return ~cur;
      default:   return cur;
    endcase
  endfunction

  function automatic logic clear_cond(cclr_e cclr, logic cma, logic cmb, logic tmris,
                                      logic tmri_rise, logic tmri_level);
    case (cclr)
      CCLR_CMA:  return cma;
      CCLR_CMB:  return cmb;
      CCLR_TMRI: return tmris ? tmri_level : tmri_rise;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/timer_clk_sel.sv
// Per-channel count-source selection: TMCI/TMRI synchronizers, edge detect
// and prescaler tap. Produces an unregistered count request.
module timer_clk_sel
  import timer_pkg::*;
#(
  parameter int CLK_SELECT_BIT_WIDTH  = 5,
  parameter int EDGE_SELECT_BIT_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             tmci,
  input  logic                             tmri,
  input  logic [CLK_SELECT_BIT_WIDTH-1:0]  clk_select,
  input  logic [PRESC_WIDTH-1:0]           prescaler,
  input  logic                             cascade_event,
  output logic                             count_req,
  output logic [EDGE_SELECT_BIT_WIDTH-1:0] cnt_edge,
  output logic                             tmri_rise,
  output logic                             tmri_level
);

  logic tmci_s1, tmci_s2, tmci_d;
  logic tmri_s1, tmri_s2, tmri_d;
  cks_e cks;
  logic icks0;
  logic tap;
  logic ext_rise, ext_fall;
  logic unused_reserved;

  assign cks             = cks_e'(clk_select[2:0]);
  assign icks0           = clk_select[3];
  assign unused_reserved = clk_select[4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmci_s1 <= 1'b0;
      tmci_s2 <= 1'b0;
      tmci_d  <= 1'b0;
      tmri_s1 <= 1'b0;
      tmri_s2 <= 1'b0;
      tmri_d  <= 1'b0;
    end else begin
      tmci_s1 <= tmci;
      tmci_s2 <= tmci_s1;
      tmci_d  <= tmci_s2;
      tmri_s1 <= tmri;
      tmri_s2 <= tmri_s1;
      tmri_d  <= tmri_s2;
    end
  end

  assign tap        = &(prescaler | ~prescale_mask(cks, icks0));
  assign ext_rise   = tmci_s2 & ~tmci_d;
  assign ext_fall   = ~tmci_s2 & tmci_d;
  assign tmri_rise  = tmri_s2 & ~tmri_d;
  assign tmri_level = tmri_s2;

  always_comb begin
    count_req = 1'b0;
    cnt_edge  = PROHIBITED;
    case (cks)
      CKS_DIV_A, CKS_DIV_B, CKS_DIV_C: begin
        count_req = tap;
        cnt_edge  = RISING_EDGE;
      end
      CKS_CASCADE: begin
        count_req = cascade_event;
        cnt_edge  = RISING_EDGE;
      end
      CKS_EXT_RISE: begin
        count_req = ext_rise;
        cnt_edge  = RISING_EDGE;
      end
      CKS_EXT_FALL: begin
        count_req = ext_fall;
        cnt_edge  = FALLING_EDGE;
      end
      CKS_EXT_BOTH: begin
        count_req = ext_rise | ext_fall;
        cnt_edge  = BOTH_EDGES;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/timer_unit_ctrl.sv
// Control logic for one two-channel 8-bit timer unit: count enables,
// counter clears, compare/overflow flags, interrupts, TMO and A/D trigger.
module timer_unit_ctrl
  import timer_pkg::*;
#(
  parameter int BIT_WIDTH             = 8,
  parameter int CLK_SELECT_BIT_WIDTH  = 5,
  parameter int EDGE_SELECT_BIT_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             tmci0,
  input  logic                             tmci1,
  input  logic                             tmri0,
  input  logic                             tmri1,
  input  logic [BIT_WIDTH-1:0]             tcr0,
  input  logic [BIT_WIDTH-1:0]             tcr1,
  input  logic [BIT_WIDTH-1:0]             tccr0,
  input  logic [BIT_WIDTH-1:0]             tccr1,
  input  logic [BIT_WIDTH-1:0]             tcsr0,
  input  logic [BIT_WIDTH-1:0]             tcsr1,
  input  logic [BIT_WIDTH-1:0]             tcnt0,
  input  logic [BIT_WIDTH-1:0]             tcnt1,
  input  logic [BIT_WIDTH-1:0]             tcora0,
  input  logic [BIT_WIDTH-1:0]             tcora1,
  input  logic [BIT_WIDTH-1:0]             tcorb0,
  input  logic [BIT_WIDTH-1:0]             tcorb1,
  output logic                             cnt_en0,
  output logic                             cnt_en1,
  output logic [EDGE_SELECT_BIT_WIDTH-1:0] cnt_edge0,
  output logic [EDGE_SELECT_BIT_WIDTH-1:0] cnt_edge1,
  output logic                             cnt_clr0,
  output logic                             cnt_clr1,
  output logic                             cma0,
  output logic                             cma1,
  output logic                             cmb0,
  output logic                             cmb1,
  output logic                             ovf0,
  output logic                             ovf1,
  output logic                             cmia0,
  output logic                             cmia1,
  output logic                             cmib0,
  output logic                             cmib1,
  output logic                             ovi0,
  output logic                             ovi1,
  output logic                             tmo0,
  output logic                             tmo1,
  output logic                             adc_request
);

  logic [PRESC_WIDTH-1:0] prescaler;
  logic cma0_q, cmb0_q, cma1_q, cmb1_q;
  logic a_entry0, b_entry0, a_entry1, b_entry1;
  logic count_req0, count_req1;
  logic clr_req0, clr_req1;
  logic tmri_rise0, tmri_rise1, tmri_level0, tmri_level1;
  logic unused_bits;

  assign unused_bits = ^{tccr0[7:4], tccr0[2], tccr1[7:4], tccr1[2], tcsr1[TCSR_ADTE]};

  assign cma0 = (tcnt0 == tcora0);
  assign cmb0 = (tcnt0 == tcorb0);
  assign ovf0 = &tcnt0;
  assign cma1 = (tcnt1 == tcora1);
  assign cmb1 = (tcnt1 == tcorb1);
  assign ovf1 = &tcnt1;

  assign a_entry0 = cma0 & ~cma0_q;
  assign b_entry0 = cmb0 & ~cmb0_q;
  assign a_entry1 = cma1 & ~cma1_q;
  assign b_entry1 = cmb1 & ~cmb1_q;

  assign cmib0 = tcsr0[TCSR_CMFB] & tcr0[TCR_CMIEB];
  assign cmia0 = tcsr0[TCSR_CMFA] & tcr0[TCR_CMIEA];
  assign ovi0  = tcsr0[TCSR_OVF]  & tcr0[TCR_OVIE];
  assign cmib1 = tcsr1[TCSR_CMFB] & tcr1[TCR_CMIEB];
  assign cmia1 = tcsr1[TCSR_CMFA] & tcr1[TCR_CMIEA];
  assign ovi1  = tcsr1[TCSR_OVF]  & tcr1[TCR_OVIE];

  // Channel 0 cascades on a channel 1 overflow that is actually being counted;
  // channel 1 cascades on channel 0 compare-match-A entry.
  timer_clk_sel #(
    .CLK_SELECT_BIT_WIDTH (CLK_SELECT_BIT_WIDTH),
    .EDGE_SELECT_BIT_WIDTH(EDGE_SELECT_BIT_WIDTH)
  ) u_clk_sel0 (
    .clk          (clk),
    .rst          (rst),
    .tmci         (tmci0),
    .tmri         (tmri0),
    .clk_select   ({tccr0[1:0], tcr0[2:0]}),
    .prescaler    (prescaler),
    .cascade_event(ovf1 & cnt_en1),
    .count_req    (count_req0),
    .cnt_edge     (cnt_edge0),
    .tmri_rise    (tmri_rise0),
    .tmri_level   (tmri_level0)
  );

  timer_clk_sel #(
    .CLK_SELECT_BIT_WIDTH (CLK_SELECT_BIT_WIDTH),
    .EDGE_SELECT_BIT_WIDTH(EDGE_SELECT_BIT_WIDTH)
  ) u_clk_sel1 (
    .clk          (clk),
    .rst          (rst),
    .tmci         (tmci1),
    .tmri         (tmri1),
    .clk_select   ({tccr1[1:0], tcr1[2:0]}),
    .prescaler    (prescaler),
    .cascade_event(a_entry0),
    .count_req    (count_req1),
    .cnt_edge     (cnt_edge1),
    .tmri_rise    (tmri_rise1),
    .tmri_level   (tmri_level1)
  );

  assign clr_req0 = clear_cond(cclr_e'(tcr0[TCR_CCLR_MSB:TCR_CCLR_LSB]), cma0, cmb0,
                               tccr0[TCCR_TMRIS], tmri_rise0, tmri_level0);
  assign clr_req1 = clear_cond(cclr_e'(tcr1[TCR_CCLR_MSB:TCR_CCLR_LSB]), cma1, cmb1,
                               tccr1[TCCR_TMRIS], tmri_rise1, tmri_level1);

  // A clear suppresses a count in the same cycle; on simultaneous entries A's action wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler   <= '0;
      cma0_q      <= 1'b0;
      cmb0_q      <= 1'b0;
      cma1_q      <= 1'b0;
      cmb1_q      <= 1'b0;
      cnt_en0     <= 1'b0;
      cnt_en1     <= 1'b0;
      cnt_clr0    <= 1'b0;
      cnt_clr1    <= 1'b0;
      tmo0        <= 1'b0;
      tmo1        <= 1'b0;
      adc_request <= 1'b0;
    end else begin
      prescaler   <= prescaler + 1'b1;
      cma0_q      <= cma0;
      cmb0_q      <= cmb0;
      cma1_q      <= cma1;
      cmb1_q      <= cmb1;
      cnt_en0     <= count_req0 & ~clr_req0;
      cnt_en1     <= count_req1 & ~clr_req1;
      cnt_clr0    <= clr_req0;
      cnt_clr1    <= clr_req1;
      if (a_entry0)      tmo0 <= os_apply(os_e'(tcsr0[1:0]), tmo0);
      else if (b_entry0) tmo0 <= os_apply(os_e'(tcsr0[3:2]), tmo0);
      if (a_entry1)      tmo1 <= os_apply(os_e'(tcsr1[1:0]), tmo1);
      else if (b_entry1) tmo1 <= os_apply(os_e'(tcsr1[3:2]), tmo1);
      adc_request <= a_entry0 & tcsr0[TCSR_ADTE];
    end
  end

endmodule

// File: tb/tb_timer_unit_ctrl.sv
// Self-checking bench for timer_unit_ctrl: comparator/interrupt vector table
// plus hand-written sequences for prescaler, TMCI, TMRI, TMO and A/D timing.
module tb_timer_unit_ctrl;

  logic       clk, rst;
  logic       tmci0, tmci1, tmri0, tmri1;
  logic [7:0] tcr0, tcr1, tccr0, tccr1, tcsr0, tcsr1;
  logic [7:0] tcnt0, tcnt1, tcora0, tcora1, tcorb0, tcorb1;
  logic       cnt_en0, cnt_en1, cnt_clr0, cnt_clr1;
  logic [1:0] cnt_edge0, cnt_edge1;
  logic       cma0, cma1, cmb0, cmb1, ovf0, ovf1;
  logic       cmia0, cmia1, cmib0, cmib1, ovi0, ovi1;
  logic       tmo0, tmo1, adc_request;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0] tcnt, tcora, tcorb, tcr, tcsr;
    logic [5:0] exp;  // {cma, cmb, ovf, cmia, cmib, ovi}
  } vec_t;
  vec_t vecs[9];

  timer_unit_ctrl dut (
    .clk(clk), .rst(rst),
    .tmci0(tmci0), .tmci1(tmci1), .tmri0(tmri0), .tmri1(tmri1),
    .tcr0(tcr0), .tcr1(tcr1), .tccr0(tccr0), .tccr1(tccr1),
    .tcsr0(tcsr0), .tcsr1(tcsr1), .tcnt0(tcnt0), .tcnt1(tcnt1),
    .tcora0(tcora0), .tcora1(tcora1), .tcorb0(tcorb0), .tcorb1(tcorb1),
    .cnt_en0(cnt_en0), .cnt_en1(cnt_en1), .cnt_edge0(cnt_edge0), .cnt_edge1(cnt_edge1),
    .cnt_clr0(cnt_clr0), .cnt_clr1(cnt_clr1),
    .cma0(cma0), .cma1(cma1), .cmb0(cmb0), .cmb1(cmb1), .ovf0(ovf0), .ovf1(ovf1),
    .cmia0(cmia0), .cmia1(cmia1), .cmib0(cmib0), .cmib1(cmib1), .ovi0(ovi0), .ovi1(ovi1),
    .tmo0(tmo0), .tmo1(tmo1), .adc_request(adc_request)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  function automatic logic [15:0] regs_now();
    return 16'({cnt_en0, cnt_en1, cnt_clr0, cnt_clr1, tmo0, tmo1, adc_request});
  endfunction

  task automatic check_pop(input string name, input logic [15:0] act);
    logic [15:0] exp;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: got %h, required value missing from queue", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_err++;
        $display("FAIL %s: got %h required %h", name, act, exp);
      end
    end
  endtask

  task automatic drive_ch1(input logic [7:0] cnt, a, b, cr, sr);
    tcnt1 = cnt; tcora1 = a; tcorb1 = b; tcr1 = cr; tcsr1 = sr;
  endtask

  initial begin
    vecs[0] = '{8'h00, 8'h10, 8'h20, 8'h00, 8'h00, 6'b000000};
    vecs[1] = '{8'h10, 8'h10, 8'h20, 8'h00, 8'h00, 6'b100000};
    vecs[2] = '{8'h20, 8'h10, 8'h20, 8'h00, 8'h00, 6'b010000};
    vecs[3] = '{8'h33, 8'h33, 8'h33, 8'hE0, 8'hC0, 6'b110110};
    vecs[4] = '{8'hFF, 8'h10, 8'h20, 8'h20, 8'h20, 6'b001001};
    vecs[5] = '{8'hFF, 8'h10, 8'h20, 8'h00, 8'h20, 6'b001000};
    vecs[6] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'hE0, 6'b111111};
    vecs[7] = '{8'h00, 8'hFF, 8'h00, 8'h40, 8'hC0, 6'b010100};
    vecs[8] = '{8'h7F, 8'h80, 8'h7F, 8'hA0, 8'h60, 6'b010001};

    rst = 1'b1;
    tmci0 = 0; tmci1 = 0; tmri0 = 0; tmri1 = 0;
    tcr0 = 8'h01; tcr1 = 8'h00; tccr0 = 0; tccr1 = 0; tcsr0 = 0; tcsr1 = 0;
    tcnt0 = 0; tcnt1 = 0; tcora0 = 8'hA0; tcorb0 = 8'hB0; tcora1 = 8'hA0; tcorb1 = 8'hB0;

    // Reset state
    repeat (3) @(negedge clk);
    exp_q.push_back(16'h0000);
    check_pop("reset_regs", regs_now());
    rst = 1'b0;

    // CKS=001, ICKS0=0: pulse every 8 clk, first at clk 8
    for (int k = 1; k <= 24; k++) exp_q.push_back(16'({2'b01, (k % 8 == 0), 1'b0}));
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      check_pop("presc_div8", 16'({cnt_edge0, cnt_en0, cnt_en1}));
    end

    // CKS=110: rising edge ignored, falling edge counted 3 clk later
    tcr0 = 8'h06; tmci0 = 1'b1;
    for (int k = 1; k <= 6; k++) exp_q.push_back(16'({2'b10, 1'b0}));
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check_pop("tmci_rise_ignored", 16'({cnt_edge0, cnt_en0}));
    end
    tmci0 = 1'b0;
    for (int k = 1; k <= 6; k++) exp_q.push_back(16'({2'b10, (k == 3)}));
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check_pop("tmci_fall", 16'({cnt_edge0, cnt_en0}));
    end
    tcr0 = 8'h00;

    // TMRI clear on ch1: rising-edge pulse, then level mode
    tcr1 = 8'h18; tmri1 = 1'b1;
    for (int k = 1; k <= 5; k++) exp_q.push_back(16'(k == 3));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check_pop("tmri_edge_clr", 16'(cnt_clr1));
    end
    tccr1 = 8'h08;
    for (int k = 1; k <= 2; k++) exp_q.push_back(16'h0001);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      check_pop("tmri_level_clr", 16'(cnt_clr1));
    end
    tmri1 = 1'b0;
    for (int k = 1; k <= 3; k++) exp_q.push_back(16'(k < 3));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_pop("tmri_level_drop", 16'(cnt_clr1));
    end
    tcr1 = 8'h00; tccr1 = 8'h00;

    // Comparator / interrupt table on ch1
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive_ch1(vecs[i].tcnt, vecs[i].tcora, vecs[i].tcorb, vecs[i].tcr, vecs[i].tcsr);
      exp_q.push_back(16'(vecs[i].exp));
      #1;
      check_pop("cmp_table", 16'({cma1, cmb1, ovf1, cmia1, cmib1, ovi1}));
    end

    // Randomised comparator vectors against a small model
    for (int i = 0; i < 8; i++) begin
      logic [7:0] c, a, b, cr, sr;
      @(negedge clk);
      c  = 8'($urandom_range(0, 255));
      a  = ($urandom_range(0, 1) == 1) ? c : 8'($urandom_range(0, 255));
      b  = ($urandom_range(0, 1) == 1) ? c : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) c = 8'hFF;
      cr = {3'($urandom_range(0, 7)), 5'b0};
      sr = {3'($urandom_range(0, 7)), 5'b0};
      drive_ch1(c, a, b, cr, sr);
      exp_q.push_back(16'({c == a, c == b, c == 8'hFF, sr[6] & cr[6], sr[7] & cr[7], sr[5] & cr[5]}));
      #1;
      check_pop("cmp_random", 16'({cma1, cmb1, ovf1, cmia1, cmib1, ovi1}));
    end
    @(negedge clk);
    drive_ch1(8'h00, 8'hA0, 8'hB0, 8'h00, 8'h00);

    // Compare-match A clear and TMO toggle on ch0
    tcr0 = 8'h08; tcsr0 = 8'h03; tcora0 = 8'h40; tcorb0 = 8'hB0; tcnt0 = 8'h00;
    @(negedge clk);
    tcnt0 = 8'h40;
    exp_q.push_back(16'b100);
    #1 check_pop("cma_comb", 16'({cma0, cnt_clr0, tmo0}));
    exp_q.push_back(16'b111);
    @(negedge clk) check_pop("cma_clr_toggle", 16'({cma0, cnt_clr0, tmo0}));
    exp_q.push_back(16'b111);
    @(negedge clk) check_pop("cma_hold", 16'({cma0, cnt_clr0, tmo0}));
    tcnt0 = 8'h41;
    exp_q.push_back(16'b001);
    @(negedge clk) check_pop("cma_leave", 16'({cma0, cnt_clr0, tmo0}));
    tcnt0 = 8'h40;
    exp_q.push_back(16'b110);
    @(negedge clk) check_pop("cma_toggle_back", 16'({cma0, cnt_clr0, tmo0}));
    tcnt0 = 8'h00;
    @(negedge clk);

    // Simultaneous A and B entry: A (drive 0) beats B (drive 1)
    tcr0 = 8'h00; tcsr0 = 8'h09; tcorb0 = 8'h50; tcnt0 = 8'h50;
    exp_q.push_back(16'h0001);
    @(negedge clk) check_pop("b_entry_high", 16'(tmo0));
    tcnt0 = 8'h00; tcora0 = 8'h60; tcorb0 = 8'h60;
    @(negedge clk);
    tcnt0 = 8'h60;
    exp_q.push_back(16'h0000);
    @(negedge clk) check_pop("ab_same_clk", 16'(tmo0));

    // A/D request pulse, then reset mid-pulse
    tcsr0 = 8'h10; tcora0 = 8'h70; tcorb0 = 8'hB0; tcnt0 = 8'h00;
    @(negedge clk);
    tcnt0 = 8'h70;
    exp_q.push_back(16'h0000);
    #1 check_pop("adc_before", 16'(adc_request));
    exp_q.push_back(16'h0001);
    @(negedge clk) check_pop("adc_pulse", 16'(adc_request));
    exp_q.push_back(16'h0000);
    @(negedge clk) check_pop("adc_one_clk", 16'(adc_request));
    tcnt0 = 8'h00;
    @(negedge clk);
    tcnt0 = 8'h70;
    exp_q.push_back(16'h0001);
    @(negedge clk) check_pop("adc_pulse2", 16'(adc_request));
    rst = 1'b1;
    exp_q.push_back(16'h0000);
    #1 check_pop("adc_rst_mid", regs_now());
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
